// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the sequencer and the register/ALU blocks of the 8-bit bus CPU.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface ctrl_sequencer_if #(
  parameter int OP_W   = 4,
  parameter int STEP_W = 3
);
  logic [OP_W-1:0]   opcode;
  logic              flag_c;
  logic              flag_z;
  logic [STEP_W-1:0] step;
  logic              halted;
  logic pc_inc, pc_rd, pc_wr, mar_wr, ram_rd, ram_wr, ir_wr, ir_rd;
  logic a_wr, a_rd, b_wr, alu_rd, alu_sub, flags_wr, out_wr;

  modport master (
    input  opcode, flag_c, flag_z,
    output step, halted,
    output pc_inc, pc_rd, pc_wr, mar_wr, ram_rd, ram_wr, ir_wr, ir_rd,
    output a_wr, a_rd, b_wr, alu_rd, alu_sub, flags_wr, out_wr
  );

  modport slave (
    output opcode, flag_c, flag_z,
    input  step, halted,
    input  pc_inc, pc_rd, pc_wr, mar_wr, ram_rd, ram_wr, ir_wr, ir_rd,
    input  a_wr, a_rd, b_wr, alu_rd, alu_sub, flags_wr, out_wr
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// T-state counter and opcode decode driving all bus strobes of the 8-bit CPU.
// Optional CTRL_EARLY_END_EN: return to T0 right after each opcode's last used step.
module ctrl_sequencer #(
  parameter int OP_W   = 4,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              clr,
  ctrl_sequencer_if.master  bus
);

  typedef enum logic [STEP_W-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  step_t step_r, step_nxt_s, last_step_s;
  logic  halted_r, halted_nxt_s;

  // State register: T-state counter and halt latch.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step_r   <= T0;
      halted_r <= 1'b0;
    end else begin
      step_r   <= step_nxt_s;
      halted_r <= halted_nxt_s;
    end
  end

  // Final T-state of the current instruction.
  always_comb begin
`ifdef CTRL_EARLY_END_EN
    case (bus.opcode)
      OP_LDA, OP_STA: last_step_s = T3;
      OP_ADD, OP_SUB: last_step_s = T4;
      default:        last_step_s = T2;
    endcase
`else
    last_step_s = T4;
`endif
  end

  // Next-state: advance/wrap the step; HLT freezes the step at T2.
  always_comb begin
    step_nxt_s   = step_r;
    halted_nxt_s = halted_r;
    if (halted_r) begin
      step_nxt_s = step_r;
    end else if ((step_r == T2) && (bus.opcode == OP_HLT)) begin
      halted_nxt_s = 1'b1;
    end else begin
      case (step_r)
        T0:         step_nxt_s = T1;
        T1:         step_nxt_s = T2;
        T2, T3, T4: step_nxt_s = (step_r == last_step_s) ? T0 : step_t'(step_r + 3'd1);
        default:    step_nxt_s = T0;
      endcase
    end
  end

  // Strobe decode, forced low during clr and after halt.
  always_comb begin
    bus.pc_inc   = 1'b0;
    bus.pc_rd    = 1'b0;
    bus.pc_wr    = 1'b0;
    bus.mar_wr   = 1'b0;
    bus.ram_rd   = 1'b0;
    bus.ram_wr   = 1'b0;
    bus.ir_wr    = 1'b0;
    bus.ir_rd    = 1'b0;
    bus.a_wr     = 1'b0;
    bus.a_rd     = 1'b0;
    bus.b_wr     = 1'b0;
    bus.alu_rd   = 1'b0;
    bus.alu_sub  = 1'b0;
    bus.flags_wr = 1'b0;
    bus.out_wr   = 1'b0;
    if (clr || halted_r) begin
      bus.pc_inc = 1'b0;
    end else begin
      case (step_r)
        T0: begin
          bus.pc_rd  = 1'b1;
          bus.mar_wr = 1'b1;
        end
        T1: begin
          bus.ram_rd = 1'b1;
          bus.ir_wr  = 1'b1;
          bus.pc_inc = 1'b1;
        end
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus.ir_rd  = 1'b1;
              bus.mar_wr = 1'b1;
            end
            OP_LDI: begin
              bus.ir_rd = 1'b1;
              bus.a_wr  = 1'b1;
            end
            OP_JMP: begin
              bus.ir_rd = 1'b1;
              bus.pc_wr = 1'b1;
            end
            OP_JC: begin
              bus.ir_rd = 1'b1;
              bus.pc_wr = bus.flag_c;
            end
            OP_JZ: begin
              bus.ir_rd = 1'b1;
              bus.pc_wr = bus.flag_z;
            end
            OP_OUT: begin
              bus.a_rd   = 1'b1;
              bus.out_wr = 1'b1;
            end
            default: bus.ir_rd = 1'b0;
          endcase
        end
        T3: begin
          case (bus.opcode)
            OP_LDA: begin
              bus.ram_rd = 1'b1;
              bus.a_wr   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.ram_rd = 1'b1;
              bus.b_wr   = 1'b1;
            end
            OP_STA: begin
              bus.a_rd   = 1'b1;
              bus.ram_wr = 1'b1;
            end
            default: bus.ram_rd = 1'b0;
          endcase
        end
        T4: begin
          if ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB)) begin
            bus.alu_rd   = 1'b1;
            bus.a_wr     = 1'b1;
            bus.flags_wr = 1'b1;
            bus.alu_sub  = (bus.opcode == OP_SUB);
          end else begin
            bus.alu_rd = 1'b0;
          end
        end
        default: bus.pc_rd = 1'b0;
      endcase
    end
  end

  assign bus.step   = step_r;
  assign bus.halted = halted_r;

endmodule
